// File: rtl/mcca_adder_reg.sv
// rtl/mcca_adder_reg.sv - Manchester carry-chain adder with one registered output stage
// Optional MCCA_GROUP_PG_EN adds registered per-group propagate/generate outputs.
module mcca_adder_reg #(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic            out_valid,
    output logic [SIZE-1:0] sum,
    output logic            cout
`ifdef MCCA_GROUP_PG_EN
    ,
    output logic [SIZE/4-1:0] grp_p,
    output logic [SIZE/4-1:0] grp_g
`endif
);

    localparam int NGRP = SIZE / 4;

    generate
        if (SIZE < 4 || (SIZE % 4) != 0) begin : g_bad_size
            $error("mcca_adder_reg: SIZE must be a multiple of 4 and at least 4");
        end
    endgenerate

    logic [SIZE-1:0] p;
    logic [SIZE-1:0] g;
    logic [SIZE-1:0] s;
    logic [SIZE:0]   c;

    assign p    = a ^ b;
    assign g    = a & b;
    assign c[0] = cin;

    // Each stage passes the incoming carry when p, otherwise drives g (generate) or 0 (kill).
    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        for (genvar j = 0; j < 4; j++) begin : g_bit
            assign c[4*k+j+1] = p[4*k+j] ? c[4*k+j] : g[4*k+j];
        end
    end

    assign s = p ^ c[SIZE-1:0];

`ifdef MCCA_GROUP_PG_EN
    logic [NGRP-1:0] grp_p_d;
    logic [NGRP-1:0] grp_g_d;

    for (genvar k = 0; k < NGRP; k++) begin : g_pg
        assign grp_p_d[k] = &p[4*k +: 4];
        assign grp_g_d[k] = g[4*k+3]
                          | (p[4*k+3] & g[4*k+2])
                          | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                          | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_p <= '0;
            grp_g <= '0;
        end else if (in_valid) begin
            grp_p <= grp_p_d;
            grp_g <= grp_g_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= s;
                cout <= c[SIZE];
            end
        end
    end

endmodule

// File: tb/tb_mcca_adder_reg.sv
// tb/tb_mcca_adder_reg.sv - scoreboard bench for mcca_adder_reg at SIZE=16
module tb_mcca_adder_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic [15:0] sum;
    logic        cout;
`ifdef MCCA_GROUP_PG_EN
    logic [3:0]  grp_p;
    logic [3:0]  grp_g;
`endif

    mcca_adder_reg #(.SIZE(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout)
`ifdef MCCA_GROUP_PG_EN
        ,
        .grp_p     (grp_p),
        .grp_g     (grp_g)
`endif
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic [3:0]  gp;
        logic [3:0]  gg;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        exp_t        e;
        logic [16:0] full;
        logic [4:0]  nib;
        @(posedge clk);
        #1;
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = 1'b1;
        full     = {1'b0, va} + {1'b0, vb} + {16'b0, vc};
        e.sum    = full[15:0];
        e.cout   = full[16];
        for (int k = 0; k < 4; k++) begin
            e.gp[k] = &(va[4*k +: 4] ^ vb[4*k +: 4]);
            nib     = {1'b0, va[4*k +: 4]} + {1'b0, vb[4*k +: 4]};
            e.gg[k] = nib[4];
        end
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sum", {16'b0, sum}, {16'b0, e.sum});
                check("cout", {31'b0, cout}, {31'b0, e.cout});
`ifdef MCCA_GROUP_PG_EN
                check("grp_p", {28'b0, grp_p}, {28'b0, e.gp});
                check("grp_g", {28'b0, grp_g}, {28'b0, e.gg});
`endif
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        #2;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_sum", {16'b0, sum}, 32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
`ifdef MCCA_GROUP_PG_EN
        check("rst_grp_p", {28'b0, grp_p}, 32'd0);
        check("rst_grp_g", {28'b0, grp_g}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        drive(16'h0000, 16'h0000, 1'b1);
        drive(16'h00CD, 16'h00BD, 1'b1);
        drive(16'h00CD, 16'h00BD, 1'b0);
        drive(16'h0001, 16'h0000, 1'b1);
        drive(16'h0001, 16'h0001, 1'b1);
        drive(16'h0001, 16'h0001, 1'b0);
        drive(16'hFFFF, 16'h0000, 1'b1);
        drive(16'hFFFF, 16'hFFFF, 1'b1);

        // Two idle cycles: valid drops, result from 0xFFFF+0xFFFF+1 must hold.
        idle();
        idle();
        @(negedge clk);
        check("hold1_out_valid", {31'b0, out_valid}, 32'd0);
        check("hold1_sum", {16'b0, sum}, 32'h0000FFFF);
        check("hold1_cout", {31'b0, cout}, 32'd1);
        idle();
        @(negedge clk);
        check("hold2_out_valid", {31'b0, out_valid}, 32'd0);
        check("hold2_sum", {16'b0, sum}, 32'h0000FFFF);
        check("hold2_cout", {31'b0, cout}, 32'd1);

        // Asynchronous reset between edges with a result in flight.
        drive(16'h1234, 16'h1111, 1'b0);
        drive(16'hABCD, 16'h8001, 1'b1);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_sum", {16'b0, sum}, 32'd0);
        check("arst_cout", {31'b0, cout}, 32'd0);
        @(negedge clk);
        check("arst_hold_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rel_valid", {31'b0, out_valid}, 32'd0);

        drive(16'h00CD, 16'h00BD, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom));
        end
        idle();
        @(negedge clk);
        @(negedge clk);
        check("sb_drain", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
